// File: rtl/seg_scan_display.sv
// seg_scan_display: multiplexed 4-digit 7-segment scanner.
//
// Scans units / tens / hundreds / mode digits one at a time at the rate of the
// external segclk strobe. segclk is sampled as data (2-flop sync and edge
// detect) and never used as a clock. The three BCD digits and the show_high
// select are snapshotted once per frame on the 3->0 index wrap, so the digits
// in a frame always come from one source and one instant.
//
// Parameters:
//   BLINK_BIT  frame-counter bit that gates lose blinking (0..7)
// Optional build macro:
//   SEG_LEADING_ZERO_BLANK_EN  blank leading-zero hundreds/tens digits
// Ports:
//   clk                        system clock, rising edge
//   clr                        asynchronous active-low reset
//   segclk                     scan-rate strobe (data, not a clock)
//   sec_u/sec_t/sec_h          current-time BCD digits
//   h_sec_u/h_sec_t/h_sec_h    high-score BCD digits
//   lose_flag/win_flag         game status (lose blinks, win lights units dp)
//   show_high                  1 selects the high score source
//   an                         active-low anodes {mode, hundreds, tens, units}
//   seg                        active-low segments {dp,g,f,e,d,c,b,a}
module seg_scan_display #(
  parameter int unsigned BLINK_BIT = 6
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       segclk,
  input  logic [3:0] sec_u,
  input  logic [3:0] sec_t,
  input  logic [3:0] sec_h,
  input  logic [3:0] h_sec_u,
  input  logic [3:0] h_sec_t,
  input  logic [3:0] h_sec_h,
  input  logic       lose_flag,
  input  logic       win_flag,
  input  logic       show_high,
  output logic [3:0] an,
  output logic [7:0] seg
);

  function automatic logic [7:0] seg_encode(input logic [3:0] digit);
    logic [7:0] glyph;
    case (digit)
      4'd0:    glyph = 8'hC0;
      4'd1:    glyph = 8'hF9;
      4'd2:    glyph = 8'hA4;
      4'd3:    glyph = 8'hB0;
      4'd4:    glyph = 8'h99;
      4'd5:    glyph = 8'h92;
      4'd6:    glyph = 8'h82;
      4'd7:    glyph = 8'hF8;
      4'd8:    glyph = 8'h80;
      4'd9:    glyph = 8'h90;
      default: glyph = 8'hBF;  // non-BCD shows '-'
    endcase
    return glyph;
  endfunction

  logic [1:0] sync_q;
  logic       sync_prev_q;
  logic       tick;

  logic [1:0] idx_q, idx_d;
  logic       show_q, show_d;
  logic [3:0] units_q, units_d, tens_q, tens_d, hund_q, hund_d;
  logic [7:0] frame_q, frame_d;
  logic [3:0] an_q, an_d;
  logic [7:0] seg_q, seg_d;

  logic       blank_tens, blank_hund;
  logic [3:0] an_sel;
  logic [7:0] glyph;

  assign tick = sync_q[1] & ~sync_prev_q;

  // Index, per-frame snapshot and frame counter.
  always_comb begin
    idx_d   = idx_q;
    show_d  = show_q;
    units_d = units_q;
    tens_d  = tens_q;
    hund_d  = hund_q;
    frame_d = frame_q;
    if (tick) begin
      idx_d = idx_q + 2'd1;
      if (idx_q == 2'd3) begin
        show_d  = show_high;
        units_d = show_high ? h_sec_u : sec_u;
        tens_d  = show_high ? h_sec_t : sec_t;
        hund_d  = show_high ? h_sec_h : sec_h;
        frame_d = frame_q + 8'd1;
      end
    end
  end

`ifdef SEG_LEADING_ZERO_BLANK_EN
  // Only a true zero blanks; a '-' digit counts as significant.
  assign blank_hund = (hund_d == 4'd0);
  assign blank_tens = blank_hund && (tens_d == 4'd0);
`else
  assign blank_hund = 1'b0;
  assign blank_tens = 1'b0;
`endif

  // Outputs are registered from the new index and new snapshot, so the digit
  // shown on a wrap tick already belongs to the new frame.
  always_comb begin
    an_d   = an_q;
    seg_d  = seg_q;
    an_sel = 4'hF;
    glyph  = 8'hFF;
    if (tick) begin
      unique case (idx_d)
        2'd0: begin
          an_sel = 4'b1110;
          glyph  = seg_encode(units_d);
          if (win_flag) glyph[7] = 1'b0;
        end
        2'd1: begin
          an_sel = 4'b1101;
          glyph  = blank_tens ? 8'hFF : seg_encode(tens_d);
        end
        2'd2: begin
          an_sel = 4'b1011;
          glyph  = blank_hund ? 8'hFF : seg_encode(hund_d);
        end
        2'd3: begin
          an_sel = 4'b0111;
          glyph  = show_d ? 8'h89 : 8'hFF;
        end
      endcase
      // Lose blanking overrides everything, including the win dp.
      if (lose_flag && frame_d[BLINK_BIT[2:0]]) begin
        an_d  = 4'hF;
        seg_d = 8'hFF;
      end else begin
        an_d  = an_sel;
        seg_d = glyph;
      end
    end
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      sync_q      <= 2'b00;
      sync_prev_q <= 1'b0;
      idx_q       <= 2'd0;
      show_q      <= 1'b0;
      units_q     <= 4'd0;
      tens_q      <= 4'd0;
      hund_q      <= 4'd0;
      frame_q     <= 8'd0;
      an_q        <= 4'hF;
      seg_q       <= 8'hFF;
    end else begin
      sync_q      <= {sync_q[0], segclk};
      sync_prev_q <= sync_q[1];
      idx_q       <= idx_d;
      show_q      <= show_d;
      units_q     <= units_d;
      tens_q      <= tens_d;
      hund_q      <= hund_d;
      frame_q     <= frame_d;
      an_q        <= an_d;
      seg_q       <= seg_d;
    end
  end

  assign an  = an_q;
  assign seg = seg_q;

endmodule
